// File: rtl/pipe_stage_pkg.sv
// Shared types and default widths for the elastic pipeline stage register.
package pipe_stage_pkg;
  localparam int DEF_DATA_W = 101;
  localparam int DEF_CTRL_W = 3;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;
endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One storage slot: valid + payload + control, with load and kill.
// Kill wins over load so a flush always empties the slot.
module pipe_slot
  import pipe_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              i_load,
  input  logic              i_kill,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  always_ff @(posedge clk) begin
    if (CLR) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (i_kill) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_ctrl  <= i_ctrl;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;
endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic interstage register with bubble gating, flush and stall counter.
// PIPE_STAGE_SKID_EN selects the two-slot skid version with registered in_ready.
module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              FLUSH,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);
  state_t              r_state, w_state_nxt;
  logic                w_in_xfer, w_out_xfer;
  logic                w_m_load, w_m_kill;
  logic [DATA_W-1:0]   w_m_din;
  logic [CTRL_W-1:0]   w_m_cin;
  logic                w_m_valid;
  logic [DATA_W-1:0]   w_m_data;
  logic [CTRL_W-1:0]   w_m_ctrl;
  logic [CNT_W-1:0]    r_stall_cnt;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = w_m_valid && out_ready;

  always_ff @(posedge clk) begin
    if (CLR) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

`ifdef PIPE_STAGE_SKID_EN
  logic              w_s_load, w_s_kill, w_s_valid, w_sel_s;
  logic [DATA_W-1:0] w_s_data;
  logic [CTRL_W-1:0] w_s_ctrl;
  logic              r_in_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (FLUSH) w_state_nxt = ST_EMPTY;
    else begin
      case (r_state)
        ST_EMPTY: if (w_in_xfer) w_state_nxt = ST_ONE;
        ST_ONE: begin
          if (w_in_xfer && !w_out_xfer)      w_state_nxt = ST_TWO;
          else if (!w_in_xfer && w_out_xfer) w_state_nxt = ST_EMPTY;
        end
        ST_TWO:   if (w_out_xfer) w_state_nxt = ST_ONE;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_m_load = 1'b0;
    w_m_kill = 1'b0;
    w_s_load = 1'b0;
    w_s_kill = 1'b0;
    w_sel_s  = 1'b0;
    if (FLUSH) begin
      w_m_kill = 1'b1;
      w_s_kill = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: w_m_load = w_in_xfer;
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) w_m_load = 1'b1;
          else if (w_in_xfer)          w_s_load = 1'b1;
          else if (w_out_xfer)         w_m_kill = 1'b1;
        end
        ST_TWO: if (w_out_xfer && w_s_valid) begin
          w_m_load = 1'b1;
          w_sel_s  = 1'b1;
          w_s_kill = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_m_din = w_sel_s ? w_s_data : in_data;
  assign w_m_cin = w_sel_s ? w_s_ctrl : in_ctrl;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_s (
    .clk(clk), .CLR(CLR), .i_load(w_s_load), .i_kill(w_s_kill),
    .i_data(in_data), .i_ctrl(in_ctrl),
    .o_valid(w_s_valid), .o_data(w_s_data), .o_ctrl(w_s_ctrl)
  );

  // Held at 1 through CLR and gated so the first cycle after release accepts.
  always_ff @(posedge clk) begin
    if (CLR) r_in_ready <= 1'b1;
    else     r_in_ready <= (w_state_nxt != ST_TWO);
  end

  assign in_ready = r_in_ready && !CLR;
`else
  always_comb begin
    w_state_nxt = r_state;
    if (FLUSH) w_state_nxt = ST_EMPTY;
    else begin
      case (r_state)
        ST_EMPTY: if (w_in_xfer) w_state_nxt = ST_ONE;
        ST_ONE:   if (!w_in_xfer && w_out_xfer) w_state_nxt = ST_EMPTY;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_m_load = 1'b0;
    w_m_kill = 1'b0;
    if (FLUSH)           w_m_kill = 1'b1;
    else if (w_in_xfer)  w_m_load = 1'b1;
    else if (w_out_xfer) w_m_kill = 1'b1;
  end

  assign w_m_din  = in_data;
  assign w_m_cin  = in_ctrl;
  assign in_ready = !CLR && ((r_state == ST_EMPTY) || out_ready);
`endif

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_m (
    .clk(clk), .CLR(CLR), .i_load(w_m_load), .i_kill(w_m_kill),
    .i_data(w_m_din), .i_ctrl(w_m_cin),
    .o_valid(w_m_valid), .o_data(w_m_data), .o_ctrl(w_m_ctrl)
  );

  always_ff @(posedge clk) begin
    if (CLR)
      r_stall_cnt <= '0;
    else if (w_m_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}}))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign out_valid = w_m_valid;
  assign out_data  = w_m_data;
  assign out_ctrl  = w_m_valid ? w_m_ctrl : '0;
  assign stall_cnt = r_stall_cnt;
endmodule
